// File: rtl/state_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : state_sequencer
// Purpose  : Instruction sequencer for the simple processor. Steps through
//            the six fetch states, decodes the opcode latched in IR, runs
//            the matching execute sequence and returns to fetch. Supports
//            a memory-wait hold, an END (halt) opcode and a counter of
//            retired instructions.
// Ports    : clock       - system clock, rising edge
//            reset_n     - asynchronous active-low reset
//            start       - begin execution (sampled only in idle)
//            hold        - freeze the sequencer (memory wait)
//            opcode      - IR opcode field, sampled when leaving fetch6
//            state       - 6-bit state code driven to control_unit
//            busy        - high whenever state != idle
//            done        - one-cycle registered pulse on halt
//            instr_count - retired-instruction count (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module state_sequencer #(
  parameter int                  OPCODE_W = 8,
  parameter int                  COUNT_W  = 16,
  parameter logic [OPCODE_W-1:0] OP_LDR1  = 8'h01,
  parameter logic [OPCODE_W-1:0] OP_LDR2  = 8'h02,
  parameter logic [OPCODE_W-1:0] OP_STAC  = 8'h03,
  parameter logic [OPCODE_W-1:0] OP_ADD   = 8'h04,
  parameter logic [OPCODE_W-1:0] OP_MUL   = 8'h05,
  parameter logic [OPCODE_W-1:0] OP_END   = 8'hFF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                hold,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [5:0]          state,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  instr_count
);

  // State codes are shared with control_unit and must not be renumbered.
  typedef enum logic [5:0] {
    S_IDLE   = 6'd0,
    S_FETCH1 = 6'd1,
    S_FETCH2 = 6'd2,
    S_FETCH3 = 6'd3,
    S_FETCH4 = 6'd4,
    S_FETCH5 = 6'd5,
    S_FETCH6 = 6'd6,
    S_LDR11  = 6'd7,
    S_LDR12  = 6'd8,
    S_LDR13  = 6'd9,
    S_LDR14  = 6'd10,
    S_LDR21  = 6'd11,
    S_LDR22  = 6'd12,
    S_LDR23  = 6'd13,
    S_LDR24  = 6'd14,
    S_STAC1  = 6'd15,
    S_STAC2  = 6'd16,
    S_STAC3  = 6'd17,
    S_STAC4  = 6'd18,
    S_ADD    = 6'd19,
    S_MUL    = 6'd20
  } state_t;

  // Held as plain logic so that out-of-range codes (upsets) are
  // representable and can be steered back to idle.
  logic [5:0]         r_state;
  logic [5:0]         w_next;
  logic               r_done;
  logic               w_done;
  logic               w_retire;
  logic [COUNT_W-1:0] r_count;

  // --------------------------------------------------------------------------
  // State register, halt pulse and retire counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done;
      if (w_retire) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state decode. Hold keeps every legal non-idle state in place and
  // suppresses retire/done; idle with hold ignores start. Illegal codes
  // return to idle regardless of hold.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next   = r_state;
    w_done   = 1'b0;
    w_retire = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !hold) begin
          w_next = S_FETCH1;
        end
      end
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4, S_FETCH5,
      S_LDR11,  S_LDR12,  S_LDR13,
      S_LDR21,  S_LDR22,  S_LDR23,
      S_STAC1,  S_STAC2,  S_STAC3: begin
        // Codes within each sequence are consecutive.
        if (!hold) begin
          w_next = r_state + 6'd1;
        end
      end
      S_FETCH6: begin
        if (!hold) begin
          if (opcode == OP_LDR1) begin
            w_next = S_LDR11;
          end else if (opcode == OP_LDR2) begin
            w_next = S_LDR21;
          end else if (opcode == OP_STAC) begin
            w_next = S_STAC1;
          end else if (opcode == OP_ADD) begin
            w_next = S_ADD;
          end else if (opcode == OP_MUL) begin
            w_next = S_MUL;
          end else if (opcode == OP_END) begin
            w_next = S_IDLE;
            w_done = 1'b1;
          end else begin
            // Unknown opcode behaves as a NOP and counts as retired.
            w_next   = S_FETCH1;
            w_retire = 1'b1;
          end
        end
      end
      S_LDR14, S_LDR24, S_STAC4, S_ADD, S_MUL: begin
        if (!hold) begin
          w_next   = S_FETCH1;
          w_retire = 1'b1;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign state       = r_state;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_state_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_state_sequencer
// Purpose  : Self-checking bench for state_sequencer. A table of opcode
//            records drives single instructions from fetch1 to the next
//            fetch1 and checks every state code and the retire count; hand
//            sequences cover reset, END, hold, start-while-busy, counter
//            wrap and illegal-state recovery.
// Revision : 1.0 - initial release
// ============================================================================
module tb_state_sequencer;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        hold;
  logic [7:0]  opcode;
  logic [5:0]  state;
  logic        busy;
  logic        done;
  logic [15:0] instr_count;

  int n_tests;
  int n_fail;
  logic [15:0] cnt_model;

  typedef struct {
    logic [7:0] op;
    int         first;  // first execute state code (unused for NOP)
    int         len;    // cycles from fetch1 to next fetch1
  } vec_t;

  vec_t vecs [7];

  state_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .hold        (hold),
    .opcode      (opcode),
    .state       (state),
    .busy        (busy),
    .done        (done),
    .instr_count (instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one instruction starting in fetch1; checks each state and the count.
  task automatic run_vec(input vec_t v);
    int exp_s;
    opcode = v.op;
    check("pre_fetch1", {26'd0, state}, 32'd1);
    for (int i = 1; i < v.len; i++) begin
      tick();
      exp_s = (i <= 5) ? (i + 1) : (v.first + (i - 6));
      check("seq_state", {26'd0, state}, exp_s);
    end
    check("count_before_retire", {16'd0, instr_count}, {16'd0, cnt_model});
    tick();
    cnt_model = cnt_model + 16'd1;
    check("back_to_fetch1", {26'd0, state}, 32'd1);
    check("count_after_retire", {16'd0, instr_count}, {16'd0, cnt_model});
    check("done_low", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int cyc;
    int held;
    int in16;

    n_tests   = 0;
    n_fail    = 0;
    cnt_model = 16'd0;
    reset_n   = 1'b0;
    start     = 1'b0;
    hold      = 1'b0;
    opcode    = 8'h00;

    vecs[0] = '{op: 8'h01, first: 7,  len: 10};
    vecs[1] = '{op: 8'h02, first: 11, len: 10};
    vecs[2] = '{op: 8'h03, first: 15, len: 10};
    vecs[3] = '{op: 8'h04, first: 19, len: 7};
    vecs[4] = '{op: 8'h05, first: 20, len: 7};
    vecs[5] = '{op: 8'h7A, first: 0,  len: 6};
    vecs[6] = '{op: 8'h00, first: 0,  len: 6};

    // Reset values
    tick();
    tick();
    check("rst_state", {26'd0, state}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_count", {16'd0, instr_count}, 32'd0);
    reset_n = 1'b1;
    tick();
    check("idle_no_start", {26'd0, state}, 32'd0);

    // ADD then END
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_latency", {26'd0, state}, 32'd1);
    check("busy_fetch1", {31'd0, busy}, 32'd1);
    opcode = 8'h04;
    for (int s = 2; s <= 6; s++) begin
      tick();
      check("add_fetch", {26'd0, state}, s);
    end
    tick();
    check("add_state", {26'd0, state}, 32'd19);
    check("add_count_pending", {16'd0, instr_count}, 32'd0);
    tick();
    check("add_to_fetch1", {26'd0, state}, 32'd1);
    check("add_count", {16'd0, instr_count}, 32'd1);
    cnt_model = 16'd1;
    opcode = 8'hFF;
    for (int s = 2; s <= 6; s++) begin
      tick();
      check("end_fetch", {26'd0, state}, s);
    end
    check("done_before_end", {31'd0, done}, 32'd0);
    tick();
    check("end_idle", {26'd0, state}, 32'd0);
    check("end_done", {31'd0, done}, 32'd1);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_count", {16'd0, instr_count}, 32'd1);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_stays", {26'd0, state}, 32'd0);

    // Restart keeps count; table of single instructions
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_fetch1", {26'd0, state}, 32'd1);
    check("count_kept", {16'd0, instr_count}, 32'd1);
    for (int k = 0; k < 7; k++) begin
      run_vec(vecs[k]);
    end

    // Hold for 3 cycles in stac2
    opcode = 8'h03;
    cyc  = 0;
    held = 0;
    in16 = 0;
    for (int i = 0; i < 30; i++) begin
      if (state == 6'd16 && held < 3) begin
        hold = 1'b1;
        held++;
      end else begin
        hold = 1'b0;
      end
      if (state == 6'd16) in16++;
      tick();
      cyc++;
      if (state == 6'd1) break;
    end
    hold = 1'b0;
    cnt_model = cnt_model + 16'd1;
    check("hold_latency", cyc, 32'd13);
    check("hold_stac2_cycles", in16, 32'd4);
    check("hold_count", {16'd0, instr_count}, {16'd0, cnt_model});

    // Hold on fetch2 freezes state; start mid-instruction ignored
    opcode = 8'h7A;
    tick();
    hold = 1'b1;
    tick();
    hold = 1'b0;
    check("hold_fetch2", {26'd0, state}, 32'd2);
    tick();
    tick();
    check("at_fetch4", {26'd0, state}, 32'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy_f5", {26'd0, state}, 32'd5);
    tick();
    check("start_busy_f6", {26'd0, state}, 32'd6);
    tick();
    cnt_model = cnt_model + 16'd1;
    check("nop_to_fetch1", {26'd0, state}, 32'd1);
    check("nop_count", {16'd0, instr_count}, {16'd0, cnt_model});

    // Counter wrap
    force dut.r_count = 16'hFFFF;
    #1;
    release dut.r_count;
    #1;
    check("preload", {16'd0, instr_count}, 32'd65535);
    cnt_model = 16'hFFFF;
    run_vec(vecs[5]);
    check("wrap_zero", {16'd0, instr_count}, 32'd0);
    run_vec(vecs[6]);

    // Illegal state recovery
    force dut.r_state = 6'd40;
    #1;
    release dut.r_state;
    #1;
    check("illegal_state", {26'd0, state}, 32'd40);
    tick();
    check("illegal_to_idle", {26'd0, state}, 32'd0);
    check("illegal_no_done", {31'd0, done}, 32'd0);
    check("illegal_count", {16'd0, instr_count}, {16'd0, cnt_model});

    // Hold in idle blocks start
    hold  = 1'b1;
    start = 1'b1;
    tick();
    check("idle_hold_blocks", {26'd0, state}, 32'd0);
    hold = 1'b0;
    tick();
    start = 1'b0;
    check("idle_start_after_hold", {26'd0, state}, 32'd1);
    tick();
    tick();
    check("at_fetch3", {26'd0, state}, 32'd3);

    // Asynchronous reset mid-fetch3
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_state", {26'd0, state}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    check("async_rst_count", {16'd0, instr_count}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_idle", {26'd0, state}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/state_sequencer.md
# state_sequencer

Instruction sequencer for the simple processor. It produces the 6-bit `state` code that drives `control_unit`. It steps through the six fetch states, decodes the opcode latched in IR, runs the matching execute sequence, and returns to fetch. It also supports a memory-wait hold, an END (halt) opcode and a retired-instruction counter.

## Interface
Parameters:
- `OPCODE_W`, 8: opcode width from IR.
- `COUNT_W`, 16: width of the retired-instruction counter.
- `OP_LDR1`, 8'h01: load into R1 (ldr11..ldr14).
- `OP_LDR2`, 8'h02: load into R2 (ldr21..ldr24).
- `OP_STAC`, 8'h03: store AC (stac1..stac4).
- `OP_ADD`, 8'h04: add (single state).
- `OP_MUL`, 8'h05: multiply (single state).
- `OP_END`, 8'hFF: halt, return to idle.

Ports. Clock and reset come first. There is one clock. Reset is asynchronous and active-low.
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin execution; sampled only in idle.
- `hold`  in  1  freeze sequencer (memory wait).
- `opcode`  in  OPCODE_W  IR opcode field; valid during fetch6.
- `state`  out  6  current state code to `control_unit`.
- `busy`  out  1  high whenever `state` != idle.
- `done`  out  1  one-cycle pulse on halt.
- `instr_count`  out  COUNT_W  number of retired instructions.

## Operation
- State codes are fixed and must match `control_unit`:
  - idle=0
  - fetch1..fetch6=1..6
  - ldr11..ldr14=7..10
  - ldr21..ldr24=11..14
  - stac1..stac4=15..18
  - add=19
  - mul=20
- idle: on `start`=1 and `hold`=0, go to fetch1. Otherwise stay in idle.
- fetch1 → fetch2 → … → fetch6, one state per cycle.
- fetch6 decodes `opcode`:
  - LDR1 → ldr11
  - LDR2 → ldr21
  - STAC → stac1
  - ADD → add
  - MUL → mul
  - END → idle, with `done` pulse
  - any other value → fetch1 (NOP)
- Each execute sequence advances one state per cycle. Its last state goes to fetch1. The last states are ldr14, ldr24, stac4, add and mul.
- `instr_count` increments by 1 on each retire, then wraps modulo 2^COUNT_W. A retire is either:
  - leaving a last execute state, or
  - a NOP decode at fetch6.
- END is not counted. `instr_count` keeps its value through idle and a new `start`, and clears only on reset.
- `hold`=1 in any non-idle state: `state`, `instr_count` and `done` are frozen or held low, and `opcode` is not sampled.
- `hold`=1 in idle blocks `start`.
- `start` is ignored in every non-idle state.
- Illegal state codes 21..63 (e.g. from an upset) go to idle on the next edge. They do not assert `done` and do not increment `instr_count`.
- `busy` is combinational from `state`.

## Timing
- All state changes happen on the rising edge of `clock`.
- Reset values, applied asynchronously while `reset_n`=0:
  - `state`=0
  - `busy`=0
  - `done`=0
  - `instr_count`=0
- Reset asserted mid-instruction forces idle immediately. No partial retire is recorded.
- Start latency: `start` high at edge N in idle → `state`=1 after edge N.
- Instruction latency with no hold, fetch1 to next fetch1:
  - LDR1, LDR2, STAC: 10 cycles
  - ADD, MUL: 7 cycles
  - NOP: 6 cycles
- `opcode` is sampled only at the edge that leaves fetch6. It must be stable in that cycle.
- `done` is registered. It is high for exactly the one cycle in which `state` first reads idle after an END.
- `instr_count` updates at the same edge that leaves the retiring state.
- Each `hold` cycle inserts exactly one extra cycle in the current state.
- `control_unit` registers `control_out`, so the control word lags `state` by one cycle. This is expected and no compensation is needed here.

## Test plan
- Reset: `reset_n`=0 mid-fetch3 → `state`=0, `busy`=0, `done`=0 and `instr_count`=0 without waiting for a clock edge.
- ADD then END: `start` pulse, opcode 8'h04 then 8'hFF at the fetch6 cycles → `state` sequence 1..6, 19, 1..6, 0. `done` is high for 1 cycle and `instr_count`=1.
- LDR2 and STAC: opcode 8'h02 → states 11, 12, 13, 14, 1. Opcode 8'h03 → states 15, 16, 17, 18, 1. `instr_count` increments at the exits of 14 and 18.
- Hold: `hold`=1 for 3 cycles while in stac2 → `state` stays 16 for 4 cycles and the total STAC latency is 13 cycles.
- NOP and wrap: opcode 8'h7A at fetch6 → next state is 1. Preload 65535 retires, then one NOP → `instr_count` wraps to 0.
- Illegal state and start-while-busy: force `state`=6'd40 → idle on the next edge with `done`=0. A `start` pulse during fetch4 has no effect on the sequence.
